multi_channel_occupancy: RTL
============================

// Module: multi_channel_occupancy
// PURPOSE
//  Occupancy tracker for CHANNELS independent queues, each 0..DEPTH entries deep.
//  Up to MAX_PUSH pushes and MAX_POP pops per channel per cycle; push and pop may occur in the same cycle.
//  Provides a count, free space, margin-parameterised almost-full/almost-empty flags, and sticky overflow/underflow errors.
//  Used by multi-issue FIFOs and load/store queues that allocate or retire several entries per cycle.
// PARAMETERS
//  DEPTH           8  entries per channel; >=2
//  CHANNELS        2  independent trackers; >=1
//  MAX_PUSH        2  max pushes per channel per cycle; >=1, <=DEPTH
//  MAX_POP         2  max pops per channel per cycle; >=1, <=DEPTH
//  AF_MARGIN       1  almost_full when DEPTH-AF_MARGIN <= count < DEPTH; 1..DEPTH-1
//  AE_MARGIN       1  almost_empty when 0 < count <= AE_MARGIN; 1..DEPTH-1
// PORTS  (CW=$clog2(DEPTH+1), PW=$clog2(MAX_PUSH+1), OW=$clog2(MAX_POP+1))
//  clk           in   1             clock
//  rst           in   1             synchronous, active-high reset
//  push_cnt      in   CHANNELS*PW   per-channel entries pushed this cycle
//  pop_cnt       in   CHANNELS*OW   per-channel entries popped this cycle
//  err_clear     in   1             clears all sticky error bits
//  count         out  CHANNELS*CW   registered occupancy
//  space         out  CHANNELS*CW   DEPTH-count
//  empty         out  CHANNELS      count==0
//  valid         out  CHANNELS      count!=0
//  almost_empty  out  CHANNELS      0<count<=AE_MARGIN
//  almost_full   out  CHANNELS      DEPTH-AF_MARGIN<=count<DEPTH
//  full          out  CHANNELS      count==DEPTH
//  can_push_max  out  CHANNELS      space>=MAX_PUSH; safe to issue a full-width push next cycle
//  overflow      out  CHANNELS      sticky; a push exceeded capacity
//  underflow     out  CHANNELS      sticky; a pop exceeded occupancy
// BEHAVIOUR
//  - Reset: count=0 and error bits=0 on all channels.
//    Outputs after reset: empty=1, valid=0, space=DEPTH, can_push_max=1; all other flags 0.
//  - State per channel: one-hot vector occ[DEPTH:0], with occ[0] set at reset. All flags are direct bit ORs of occ (no adder on the flag path).
//  - count and space are encoded from occ. Both are registered and update the cycle after push_cnt/pop_cnt are sampled (1-cycle latency).
//  - Next state, using a signed net of DEPTH-width+2 bits: n = count + push_cnt - pop_cnt.
//      0<=n<=DEPTH : occ shifts by (push_cnt - pop_cnt); no error
//      n>DEPTH     : occ saturates to bit DEPTH; overflow<=1
//      n<0         : occ saturates to bit 0; underflow<=1
//  - Simultaneous push and pop: the net is applied, so push=pop leaves state unchanged.
//    A pop on an empty channel in the same cycle as an equal push is legal (net 0, no underflow).
//  - Channels are fully independent. A push or pop on channel i never affects channel j.
//  - Sticky errors: set as above. err_clear=1 clears them next cycle.
//    If clear and a new error occur in the same cycle, the set wins.
//  - rst asserted mid-operation takes precedence over all inputs, including err_clear, in that cycle.
//  - Invariant: exactly one occ bit is set at all times. This is asserted in simulation.
// STRUCTURE
//  - Sub-module occupancy_channel (one per channel, generate loop). Holds the one-hot occ, saturation, error and flag logic.
//  - Top level: packs and unpacks the per-channel buses and distributes err_clear.
//  - Shared package taiga_types: add typedef occ_flags_t, a struct of {empty, valid, almost_empty, almost_full, full, can_push_max}.
//  - Shared package taiga_types: add function onehot_to_count(), reused by other queues.
// TESTING
//  1. Reset: hold rst 2 cycles -> all channels count=0, empty=1, space=8, can_push_max=1, overflow=underflow=0.
//  2. Fill ch0 with push_cnt=2 for 4 cycles -> count 2,4,6,8. almost_full=1 at count 7-8 only when count<8, so here full=1 at 8.
//     can_push_max drops when count=7 or 8. ch1 stays empty.
//  3. Overflow: at count=7, push 2 -> count=8, overflow=1 (sticky). err_clear while pushing 1 more -> overflow stays 1 (set wins).
//     Pulse err_clear alone -> overflow=0.
//  4. Mixed traffic: count=3, push 2 + pop 2 -> count stays 3. Push 1 + pop 2 -> 2. On empty, push 1 + pop 1 -> stays 0, no underflow.
//  5. Underflow: count=1, pop 2 -> count=0, empty=1, underflow=1. The other channel is unaffected.
//  6. Reset mid-operation: rst during an overflowing push with err_clear high -> next cycle count=0, all errors 0.
//     Randomised run with a scoreboard model checks count, flags and one-hot invariant every cycle.

Source files
------------

// File: rtl/taiga_types.sv
// taiga_types: shared queue-tracking types and helpers
package taiga_types;
  typedef struct packed {
    logic empty;
    logic valid;
    logic almost_empty;
    logic almost_full;
    logic full;
    logic can_push_max;
  } occ_flags_t;
  function automatic int unsigned onehot_to_count(input logic [255:0] oh);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 256; i++) if (oh[i]) c |= i;
    return c;
  endfunction
endpackage

// File: rtl/occupancy_channel.sv
// occupancy_channel: one-hot occupancy tracker with saturation, sticky errors and flags
module occupancy_channel
  import taiga_types::*;
#(
  parameter int DEPTH = 8,
  parameter int MAX_PUSH = 2,
  parameter int MAX_POP = 2,
  parameter int AF_MARGIN = 1,
  parameter int AE_MARGIN = 1,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(MAX_PUSH + 1),
  localparam int OW = $clog2(MAX_POP + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PW-1:0] push,
  input  logic [OW-1:0] pop,
  input  logic          err_clear,
  output logic [CW-1:0] count,
  output logic [CW-1:0] space,
  output occ_flags_t    flags,
  output logic          overflow,
  output logic          underflow
);
  logic [DEPTH:0] occ, occ_nxt;
  logic [DEPTH+MAX_PUSH:0] shifted;
  logic signed [CW+1:0] n;
  logic ovf_set, unf_set;
  logic [CW-1:0] cnt_nxt;
  // net change and saturating next one-hot position
  always_comb begin
    n = $signed((CW+2)'(count)) + $signed((CW+2)'(push)) - $signed((CW+2)'(pop));
    ovf_set = n > $signed((CW+2)'(DEPTH));
    unf_set = n < 0;
    shifted = ((DEPTH+MAX_PUSH+1)'(occ) << push) >> pop;
    occ_nxt = ovf_set ? {1'b1, {DEPTH{1'b0}}} : unf_set ? {{DEPTH{1'b0}}, 1'b1} : shifted[DEPTH:0];
    cnt_nxt = CW'(onehot_to_count(256'(occ_nxt)));
  end
  // state, encoded count/space and sticky errors (set beats clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= {{DEPTH{1'b0}}, 1'b1};
      count <= '0;
      space <= CW'(DEPTH);
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      occ <= occ_nxt;
      count <= cnt_nxt;
      space <= CW'(DEPTH) - cnt_nxt;
      overflow <= ovf_set | (overflow & ~err_clear);
      underflow <= unf_set | (underflow & ~err_clear);
    end
  end
  // flags are plain ORs over the one-hot state
  always_comb begin
    flags.empty = occ[0];
    flags.valid = ~occ[0];
    flags.almost_empty = |occ[AE_MARGIN:1];
    flags.almost_full = |occ[DEPTH-1:DEPTH-AF_MARGIN];
    flags.full = occ[DEPTH];
    flags.can_push_max = |occ[DEPTH-MAX_PUSH:0];
  end
  // exactly one occupancy bit must be set outside reset
  always_ff @(posedge clk) begin
    assert (rst || $onehot(occ));
  end
endmodule

// File: rtl/multi_channel_occupancy.sv
// multi_channel_occupancy: per-channel occupancy trackers behind packed buses
module multi_channel_occupancy
  import taiga_types::*;
#(
  parameter int DEPTH = 8,
  parameter int CHANNELS = 2,
  parameter int MAX_PUSH = 2,
  parameter int MAX_POP = 2,
  parameter int AF_MARGIN = 1,
  parameter int AE_MARGIN = 1,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(MAX_PUSH + 1),
  localparam int OW = $clog2(MAX_POP + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CHANNELS*PW-1:0] push_cnt,
  input  logic [CHANNELS*OW-1:0] pop_cnt,
  input  logic                   err_clear,
  output logic [CHANNELS*CW-1:0] count,
  output logic [CHANNELS*CW-1:0] space,
  output logic [CHANNELS-1:0]    empty,
  output logic [CHANNELS-1:0]    valid,
  output logic [CHANNELS-1:0]    almost_empty,
  output logic [CHANNELS-1:0]    almost_full,
  output logic [CHANNELS-1:0]    full,
  output logic [CHANNELS-1:0]    can_push_max,
  output logic [CHANNELS-1:0]    overflow,
  output logic [CHANNELS-1:0]    underflow
);
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    occ_flags_t f;
    occupancy_channel #(
      .DEPTH(DEPTH), .MAX_PUSH(MAX_PUSH), .MAX_POP(MAX_POP),
      .AF_MARGIN(AF_MARGIN), .AE_MARGIN(AE_MARGIN)
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .push(push_cnt[g*PW +: PW]),
      .pop(pop_cnt[g*OW +: OW]),
      .err_clear(err_clear),
      .count(count[g*CW +: CW]),
      .space(space[g*CW +: CW]),
      .flags(f),
      .overflow(overflow[g]),
      .underflow(underflow[g])
    );
    assign empty[g] = f.empty;
    assign valid[g] = f.valid;
    assign almost_empty[g] = f.almost_empty;
    assign almost_full[g] = f.almost_full;
    assign full[g] = f.full;
    assign can_push_max[g] = f.can_push_max;
  end
endmodule
